// File: rtl/uart_pkg.sv
// Shared definitions for the duplex UART: parity modes, FSM state encodings and parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit to transmit/expect. Data is zero-extended so unused upper bits add no ones.
    // Odd: total ones (data + parity) odd. Even: total ones even.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        parity_bit = (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling baud tick generator: one-clk tick every DIV clocks, DIV = CLK_FREQ/(BAUD*OVERSAMPLE) rounded.
// Latency: free-running; first tick DIV clocks after rst deasserts.
// Backpressure: none (tick is a strobe).
// Ports: clk, rst (sync, active-high), tick (one-cycle pulse at counter wrap).
module uart_baud_gen #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int RATE = BAUD * OVERSAMPLE;
    localparam int DIV  = (CLK_FREQ + RATE / 2) / RATE;
    localparam int CW   = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_div_too_small
            $error("uart_baud_gen: clock divider DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_duplex_core.sv
// Full-duplex UART: independent TX and RX FSMs sharing one oversampling tick; optional UART_LOOPBACK_EN macro
// Latency: TX line drops the clk after handshake; rx_valid pulses at the centre of the last stop bit.
// Backpressure: tx_ready high only in TX idle; RX has no buffering (consumer takes rx_data before next rx_valid).
// Ports: clk/rst (sync active-high); tx_data/tx_valid/tx_ready handshake, tx pin; rx pin,
//        rx_data/rx_valid/rx_parity_err/rx_frame_err/rx_busy; loopback only when UART_LOOPBACK_EN is defined.
module uart_duplex_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int         PW    = $clog2(OVERSAMPLE);
    localparam logic [1:0] PMODE = 2'(PARITY_MODE);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_duplex_core: DATA_BITS must be 5..9");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
            $error("uart_duplex_core: OVERSAMPLE must be even and at least 8");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
            $error("uart_duplex_core: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_duplex_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic tick;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // ---------------- TX ----------------
    tx_state_t            tx_state_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 tx_q;
    logic                 tx_ready_q;
    logic [PW-1:0]        tx_phase_q;
    logic [3:0]           tx_bit_q;
    logic                 tx_stop_q;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_phase_q == PW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_phase_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
        end else begin
            if (tx_state_q != TX_IDLE && tick) begin
                tx_phase_q <= tx_bit_end ? '0 : tx_phase_q + PW'(1);
            end
            case (tx_state_q)
                TX_IDLE: begin
                    // tx_ready_q is 1 exactly in IDLE, so tx_valid alone completes the handshake here.
                    if (tx_valid) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= parity_bit(9'(tx_data), PMODE);
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_phase_q <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_q       <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                            if (PMODE != PARITY_NONE) begin
                                tx_q       <= tx_par_q;
                                tx_state_q <= TX_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_stop_q  <= 1'b0;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_q       <= 1'b1;
                        tx_stop_q  <= 1'b0;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                            tx_ready_q <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    tx_ready_q <= 1'b1;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;

    // ---------------- line muxing ----------------
    logic rx_in;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    // ---------------- RX ----------------
    rx_state_t            rx_state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [PW-1:0]        rx_phase_q;
    logic [3:0]           rx_bit_q;
    logic                 rx_stop_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_perr_acc_q, rx_ferr_acc_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q;
    logic                 rx_sample;

    // Start bit is checked half a bit in; every later sample is one full bit after the previous one.
    assign rx_sample = tick && (rx_phase_q == ((rx_state_q == RX_START) ? PW'(OVERSAMPLE / 2 - 1)
                                                                         : PW'(OVERSAMPLE - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_phase_q    <= '0;
            rx_bit_q      <= '0;
            rx_stop_q     <= 1'b0;
            rx_shift_q    <= '0;
            rx_perr_acc_q <= 1'b0;
            rx_ferr_acc_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= 1'b0;
            if (rx_state_q != RX_IDLE && tick) begin
                rx_phase_q <= rx_sample ? '0 : rx_phase_q + PW'(1);
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_phase_q    <= '0;
                        rx_perr_acc_q <= 1'b0;
                        rx_ferr_acc_q <= 1'b0;
                        rx_state_q    <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_sample) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == 4'(DATA_BITS - 1)) begin
                            rx_stop_q  <= 1'b0;
                            rx_state_q <= (PMODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_perr_acc_q <= rx_s2_q ^ parity_bit(9'(rx_shift_q), PMODE);
                        rx_stop_q     <= 1'b0;
                        rx_state_q    <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_sample) begin
                        if (rx_stop_q == 1'(STOP_BITS - 1)) begin
                            // Returning to IDLE mid stop bit lets a following start edge resync early.
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            rx_perr_q  <= rx_perr_acc_q;
                            rx_ferr_q  <= rx_ferr_acc_q | ~rx_s2_q;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_ferr_acc_q <= rx_ferr_acc_q | ~rx_s2_q;
                            rx_stop_q     <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_duplex_core.sv
// Directed bench for uart_duplex_core: three instances (8E2, 8N1, 8O1) at 160 clk per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_duplex_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // instance 0: 8E2, instance 1: 8N1, instance 2: 8O1
    logic [7:0] tx_data_e = '0, tx_data_n = '0, tx_data_o = '0;
    logic       tx_valid_e = 0, tx_valid_n = 0, tx_valid_o = 0;
    logic       rx_e = 1, rx_n = 1, rx_o = 1;
    logic       tx_ready_e, tx_ready_n, tx_ready_o;
    logic       tx_e, tx_n, tx_o;
    logic [7:0] rx_data_e, rx_data_n, rx_data_o;
    logic       rx_valid_e, rx_valid_n, rx_valid_o;
    logic       rx_perr_e, rx_perr_n, rx_perr_o;
    logic       rx_ferr_e, rx_ferr_n, rx_ferr_o;
    logic       rx_busy_e, rx_busy_n, rx_busy_o;
`ifdef UART_LOOPBACK_EN
    logic       lb = 1'b0;
    int         lb_txlow = 0;
    always @(negedge clk) if (lb && !tx_n) lb_txlow <= lb_txlow + 1;
`endif

    uart_duplex_core #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                       .PARITY_MODE(2), .STOP_BITS(2)) u_e (
        .clk(clk), .rst(rst), .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .tx(tx_e), .rx(rx_e),
`ifdef UART_LOOPBACK_EN
        .loopback(lb),
`endif
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_parity_err(rx_perr_e),
        .rx_frame_err(rx_ferr_e), .rx_busy(rx_busy_e));

    uart_duplex_core #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                       .PARITY_MODE(0), .STOP_BITS(1)) u_n (
        .clk(clk), .rst(rst), .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .tx(tx_n), .rx(rx_n),
`ifdef UART_LOOPBACK_EN
        .loopback(lb),
`endif
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_parity_err(rx_perr_n),
        .rx_frame_err(rx_ferr_n), .rx_busy(rx_busy_n));

    uart_duplex_core #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                       .PARITY_MODE(1), .STOP_BITS(1)) u_o (
        .clk(clk), .rst(rst), .tx_data(tx_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o),
        .tx(tx_o), .rx(rx_o),
`ifdef UART_LOOPBACK_EN
        .loopback(lb),
`endif
        .rx_data(rx_data_o), .rx_valid(rx_valid_o), .rx_parity_err(rx_perr_o),
        .rx_frame_err(rx_ferr_o), .rx_busy(rx_busy_o));

    int vcnt_n = 0, vcnt_o = 0, vcyc_n = 0;
    always @(negedge clk) begin
        if (rx_valid_n) begin
            vcnt_n <= vcnt_n + 1;
            vcyc_n <= cyc;
        end
        if (rx_valid_o) vcnt_o <= vcnt_o + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx_e : tx_n;
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 0) ? tx_ready_e : tx_ready_n;
    endfunction

    task automatic set_tx(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin
            tx_data_e  = d;
            tx_valid_e = v;
        end else begin
            tx_data_n  = d;
            tx_valid_n = v;
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 1) rx_n = v;
        else        rx_o = v;
    endtask

    // Starts a TX frame (or two back-to-back when nbits > 12) and samples the line mid-bit.
    task automatic tx_capture(input int w, input logic [7:0] d1, input logic [7:0] d2, input int nbits,
                              output logic [19:0] seq, output logic rdy_lo, output int t0);
        seq    = '0;
        rdy_lo = 1'b1;
        set_tx(w, d1, 1'b1);
        @(negedge clk);
        t0 = cyc;
        if (nbits > 12) set_tx(w, d2, 1'b1);
        else            set_tx(w, d1, 1'b0);
        for (int k = 0; k < nbits; k++) begin
            repeat ((k == 0) ? 80 : 160) @(negedge clk);
            seq[k] = get_tx(w);
            if (get_rdy(w)) rdy_lo = 1'b0;
            if (k == 10) set_tx(w, d2, 1'b0);
        end
    endtask

    task automatic drive_frame(input int w, input logic [7:0] d, input logic par_en, input logic par_v,
                               input logic stop_v, output int c0);
        c0 = cyc;
        set_rx(w, 1'b0);
        repeat (160) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, d[i]);
            repeat (160) @(negedge clk);
        end
        if (par_en) begin
            set_rx(w, par_v);
            repeat (160) @(negedge clk);
        end
        set_rx(w, stop_v);
        repeat (160) @(negedge clk);
        set_rx(w, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_rdy(input int w, input string tag);
        int n = 0;
        while (!get_rdy(w) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(get_rdy(w)), 32'd1);
    endtask

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [19:0] seq;
        logic        rlo;
        int          t0, c0, v0, dt;
        logic [11:0] exp_a5;
        exp_a5 = 12'b110101001010;   // bit k = k-th bit on the wire for 0xA5 8E2

        repeat (5) @(negedge clk);
        check_eq("rst_tx", 32'(tx_e), 32'd1);
        check_eq("rst_tx_ready", 32'(tx_ready_e), 32'd1);
        check_eq("rst_rx_data", 32'(rx_data_n), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid_n), 32'd0);
        check_eq("rst_perr", 32'(rx_perr_o), 32'd0);
        check_eq("rst_ferr", 32'(rx_ferr_o), 32'd0);
        check_eq("rst_busy", 32'(rx_busy_n), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // TX 8E2 0xA5
        tx_capture(0, 8'hA5, 8'hA5, 12, seq, rlo, t0);
        for (int k = 0; k < 12; k++)
            check_eq($sformatf("tx8e2_bit%0d", k), 32'(seq[k]), 32'(exp_a5[k]));
        check_eq("tx8e2_ready_low", 32'(rlo), 32'd1);
        wait_rdy(0, "tx8e2_ready_back");
        dt = cyc - t0;
        check_eq("tx8e2_frame_len_in_1911_1920", 32'(dt >= 1911 && dt <= 1920), 32'd1);
        check_eq("tx8e2_idle_line", 32'(tx_e), 32'd1);
        repeat (20) @(negedge clk);

        // reset during DATA bit 3 of 0xA5 (a 0 on the wire)
        set_tx(0, 8'hA5, 1'b1);
        @(negedge clk);
        set_tx(0, 8'hA5, 1'b0);
        repeat (80 + 160 * 4) @(negedge clk);
        check_eq("rstmid_pre_tx", 32'(tx_e), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_tx", 32'(tx_e), 32'd1);
        check_eq("rstmid_tx_ready", 32'(tx_ready_e), 32'd1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // RX 8N1 0x3C
        v0 = vcnt_n;
        drive_frame(1, 8'h3C, 1'b0, 1'b0, 1'b1, c0);
        check_eq("rx8n1_valid_count", 32'(vcnt_n - v0), 32'd1);
        check_eq("rx8n1_data", 32'(rx_data_n), 32'h3C);
        check_eq("rx8n1_perr", 32'(rx_perr_n), 32'd0);
        check_eq("rx8n1_ferr", 32'(rx_ferr_n), 32'd0);
        dt = vcyc_n - c0;
        check_eq("rx8n1_valid_at_stop_centre", 32'(dt >= 1510 && dt <= 1530), 32'd1);

        // odd parity, wrong parity bit on 0x01 (correct bit would be 0)
        v0 = vcnt_o;
        drive_frame(2, 8'h01, 1'b1, 1'b1, 1'b1, c0);
        check_eq("par_valid_count", 32'(vcnt_o - v0), 32'd1);
        check_eq("par_perr", 32'(rx_perr_o), 32'd1);
        check_eq("par_ferr", 32'(rx_ferr_o), 32'd0);

        // stop bit low
        v0 = vcnt_o;
        drive_frame(2, 8'h01, 1'b1, 1'b0, 1'b0, c0);
        check_eq("frm_valid_count", 32'(vcnt_o - v0), 32'd1);
        check_eq("frm_ferr", 32'(rx_ferr_o), 32'd1);
        check_eq("frm_perr", 32'(rx_perr_o), 32'd0);
        repeat (100) @(negedge clk);

        // clean 0x5A, odd parity bit = 1
        v0 = vcnt_o;
        drive_frame(2, 8'h5A, 1'b1, 1'b1, 1'b1, c0);
        check_eq("clean_valid_count", 32'(vcnt_o - v0), 32'd1);
        check_eq("clean_data", 32'(rx_data_o), 32'h5A);
        check_eq("clean_perr", 32'(rx_perr_o), 32'd0);
        check_eq("clean_ferr", 32'(rx_ferr_o), 32'd0);

        // 40-clk glitch
        v0 = vcnt_n;
        set_rx(1, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("glitch_busy_during", 32'(rx_busy_n), 32'd1);
        repeat (20) @(negedge clk);
        set_rx(1, 1'b1);
        repeat (100) @(negedge clk);
        check_eq("glitch_busy_after", 32'(rx_busy_n), 32'd0);
        check_eq("glitch_no_valid", 32'(vcnt_n - v0), 32'd0);
        drive_frame(1, 8'h55, 1'b0, 1'b0, 1'b1, c0);
        check_eq("glitch_next_count", 32'(vcnt_n - v0), 32'd1);
        check_eq("glitch_next_data", 32'(rx_data_n), 32'h55);

        // full duplex: TX 0x12 while RX 0xEF, 70 clk apart
        v0 = vcnt_n;
        fork
            tx_capture(1, 8'h12, 8'h12, 10, seq, rlo, t0);
            begin
                repeat (70) @(negedge clk);
                drive_frame(1, 8'hEF, 1'b0, 1'b0, 1'b1, c0);
            end
        join
        check_eq("duplex_tx_bits", 32'(seq[9:0]), 32'(10'b1000100100));
        check_eq("duplex_rx_count", 32'(vcnt_n - v0), 32'd1);
        check_eq("duplex_rx_data", 32'(rx_data_n), 32'hEF);
        wait_rdy(1, "duplex_tx_ready_back");
        repeat (20) @(negedge clk);

        // back-to-back 0x81 then 0x7E with tx_valid held
        tx_capture(1, 8'h81, 8'h7E, 20, seq, rlo, t0);
        check_eq("b2b_bits", 32'(seq), 32'(20'b1011111100_1100000010));
        wait_rdy(1, "b2b_tx_ready_back");
        repeat (20) @(negedge clk);

`ifdef UART_LOOPBACK_EN
        lb = 1'b1;
        repeat (2) @(negedge clk);
        v0 = vcnt_n;
        tx_capture(1, 8'h96, 8'h96, 10, seq, rlo, t0);
        repeat (100) @(negedge clk);
        check_eq("lb_pin_bits", 32'(seq[9:0]), 32'h3FF);
        check_eq("lb_pin_low_cycles", 32'(lb_txlow), 32'd0);
        check_eq("lb_rx_count", 32'(vcnt_n - v0), 32'd1);
        check_eq("lb_rx_data", 32'(rx_data_n), 32'h96);
        lb = 1'b0;
        repeat (20) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_duplex_core.md
Name: uart_duplex_core

Overview:
- Full-duplex, parametrised UART engine that replaces the shared-line half-duplex transmitter/receiver pair.
- Independent TX and RX paths run concurrently and share one oversampling baud tick.
- Supports configurable data width, parity and stop bits, with valid/ready on TX and a valid pulse plus error flags on RX.
- Sits between the board pins (tx, rx) and FPGA-internal logic.

Parameters:
- CLK_FREQ, 100000000: clk frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: baud ticks per bit; even, at least 8.
- DATA_BITS, 8: payload width; legal values 5..9.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 2: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tx_data  in  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX idle and able to accept.
- tx  out  1  serial line out; idles high.
- rx  in  1  serial line in; asynchronous.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_parity_err  out  1  parity mismatch on the last word.
- rx_frame_err  out  1  a stop bit was sampled low on the last word.
- rx_busy  out  1  RX is mid-frame.

Behaviour:
- Baud tick:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), rounded to nearest; compile-time error if DIV < 2.
  - The counter counts 0..DIV-1 and pulses tick for one clk at wrap.
  - The counter free-runs and clears on rst.
- Reset values: tx=1, tx_ready=1, rx_data=0, rx_valid=0, both error flags=0, rx_busy=0, both FSMs in IDLE.
- rst mid-frame aborts immediately. A partial TX frame is truncated with tx=1 on the next cycle.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Handshake occurs when tx_valid && tx_ready. tx_ready is 1 only in IDLE.
  - On handshake, tx_data is latched and the FSM enters START on the next clk.
  - Each bit lasts exactly OVERSAMPLE ticks.
  - Bit order: START drives 0, DATA drives LSB first, PARITY drives the parity bit (skipped if PARITY_MODE=0), STOP drives 1 for STOP_BITS bit times.
  - Odd parity: the parity bit makes the total count of ones odd. Even parity: the total count of ones is even.
  - After STOP the FSM returns to IDLE with tx_ready=1. Back-to-back frames have no extra idle bit.
  - tx_valid is ignored while tx_ready=0.
- RX path:
  - rx passes through a 2-flop synchroniser. Both flops reset to 1.
  - IDLE: a synchronised falling edge enters START and clears the tick phase counter.
  - START: sample at OVERSAMPLE/2 ticks. If the sample is high, treat it as a glitch and return to IDLE without asserting rx_valid. If low, go to DATA.
  - DATA: sample at the centre of each bit, i.e. every OVERSAMPLE ticks, shifting in LSB first.
  - PARITY: sample and compare.
  - STOP: sample each stop bit at its centre. Any low sample sets the frame error.
  - At the centre of the last stop bit: rx_data updates, rx_valid pulses for 1 clk, both error flags update (held until the next rx_valid), and the FSM goes to IDLE. The FSM can therefore resync on a start edge during the second half of the stop bit.
  - rx_valid pulses even when an error flag is set.
  - rx_busy = (state != IDLE).
- There is no RX buffering. The consumer must take rx_data before the next rx_valid, which comes at least one frame later.
- TX and RX are fully independent; simultaneous events on both paths do not interact.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - While loopback=1, the RX synchroniser input is the internal TX serial signal and the tx pin is held 1.
  - The loopback port must only be switched while rx_busy=0 and tx_ready=1; behaviour otherwise is undefined but must not lock either FSM.
- When not defined: no port, and rx is connected directly to the synchroniser.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE, PARITY_ODD, PARITY_EVEN constants.
  - tx_state_t and rx_state_t enums.
  - Function parity_bit(data, mode).
- Sub-module uart_baud_gen (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst, tick).
- TX and RX FSMs stay in uart_duplex_core.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and 1 bit = 160 clk.
- TX 8E2: send 0xA5 -> tx bit sequence 0, 1,0,1,0,0,1,0,1, 0, 1,1 (parity 0 since popcount is even); frame = 1920 clk; tx_ready low throughout, high again after the last stop bit.
- RX 8N1: drive 0x3C serially -> rx_valid pulses exactly once, at the centre of the stop bit; rx_data=0x3C; both error flags 0.
- Errors:
  - Odd parity with a wrong parity bit on 0x01 -> rx_parity_err=1.
  - Stop bit driven 0 -> rx_frame_err=1 and rx_valid still pulses.
  - Next clean frame clears both flags.
- Glitch: rx low for 40 clk (under half a bit) -> no rx_valid; rx_busy returns to 0; a following valid frame of 0x55 is received correctly.
- Full duplex: TX sends 0x12 while RX receives 0xEF, offset by 70 clk -> both complete correctly. Second case: tx_valid held high -> back-to-back frames with no idle gap.
- Reset mid-frame: assert rst during TX DATA bit 3 -> tx=1 and tx_ready=1 on the next clk. With UART_LOOPBACK_EN and loopback=1, sending 0x96 -> rx_data=0x96 and the tx pin stays 1.
